// File: rtl/cordic_iter_rotation.sv
// Folded CORDIC rotator: one shared X/Y/Z micro-rotation stage reused ITER times per operand.
// Optional CORDIC_GAIN_COMP_EN adds a GAIN state scaling Xout/Yout by 1/K; state_dbg: 0 IDLE, 1 RUN, 2 GAIN, 3 DONE.
module cordic_iter_rotation #(
    parameter int    DSIZE    = 16,
    parameter int    ZSIZE    = 16,
    parameter int    ITER     = 12,
    parameter string ROTTMODE = "ROTT"
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DSIZE-1:0] Xin,
    input  logic signed [DSIZE-1:0] Yin,
    input  logic signed [ZSIZE-1:0] Zin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DSIZE-1:0] Xout,
    output logic signed [DSIZE-1:0] Yout,
    output logic signed [ZSIZE-1:0] Zout,
    output logic [1:0]              state_dbg
);

    if (!(ROTTMODE == "ROTT" || ROTTMODE == "VECTOR")) begin : g_bad_mode
        $error("cordic_iter_rotation: ROTTMODE must be ROTT or VECTOR");
    end
    if (ZSIZE < 8 || ZSIZE > 32) begin : g_bad_zsize
        $error("cordic_iter_rotation: ZSIZE must be in 8..32");
    end
    if (ITER < 1 || ITER > 24) begin : g_bad_iter
        $error("cordic_iter_rotation: ITER must be in 1..24");
    end
    if (DSIZE < 2) begin : g_bad_dsize
        $error("cordic_iter_rotation: DSIZE must be at least 2");
    end

    localparam bit          VEC_MODE = (ROTTMODE == "VECTOR");
    localparam logic [4:0]  LAST_I   = 5'(ITER - 1);
    localparam int          RSH      = 32 - ZSIZE;
    localparam int          RND_SH   = (ZSIZE < 32) ? (31 - ZSIZE) : 0;
    localparam logic [32:0] RND      = (ZSIZE < 32) ? (33'd1 << RND_SH) : 33'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAIN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic signed [DSIZE-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZSIZE-1:0] z_q, z_d;
    logic [4:0]              i_q, i_d;
    logic signed [DSIZE-1:0] xo_q, xo_d, yo_q, yo_d;
    logic signed [ZSIZE-1:0] zo_q, zo_d;

    logic signed [DSIZE-1:0] x_sh, y_sh, x_rot, y_rot;
    logic signed [ZSIZE-1:0] a_i, z_rot;
    logic                    d_pos;

    // atan(2^-i) with 2^32 = one full turn
    function automatic logic [31:0] atan32(input logic [4:0] idx);
        case (idx)
            5'd0:    atan32 = 32'h2000_0000;
            5'd1:    atan32 = 32'h12E4_051E;
            5'd2:    atan32 = 32'h09FB_385B;
            5'd3:    atan32 = 32'h0511_11D4;
            5'd4:    atan32 = 32'h028B_0D43;
            5'd5:    atan32 = 32'h0145_D7E1;
            5'd6:    atan32 = 32'h00A2_F61E;
            5'd7:    atan32 = 32'h0051_7C55;
            5'd8:    atan32 = 32'h0028_BE53;
            5'd9:    atan32 = 32'h0014_5F2F;
            5'd10:   atan32 = 32'h000A_2F98;
            5'd11:   atan32 = 32'h0005_17CC;
            5'd12:   atan32 = 32'h0002_8BE6;
            5'd13:   atan32 = 32'h0001_45F3;
            5'd14:   atan32 = 32'h0000_A2FA;
            5'd15:   atan32 = 32'h0000_517D;
            5'd16:   atan32 = 32'h0000_28BE;
            5'd17:   atan32 = 32'h0000_145F;
            5'd18:   atan32 = 32'h0000_0A30;
            5'd19:   atan32 = 32'h0000_0518;
            5'd20:   atan32 = 32'h0000_028C;
            5'd21:   atan32 = 32'h0000_0146;
            5'd22:   atan32 = 32'h0000_00A3;
            5'd23:   atan32 = 32'h0000_0051;
            default: atan32 = 32'h0000_0000;
        endcase
    endfunction

    // Narrow the 32-bit angle to ZSIZE bits, rounding half up
    function automatic logic [ZSIZE-1:0] atan_z(input logic [4:0] idx);
        logic [32:0] t;
        t = {1'b0, atan32(idx)} + RND;
        return ZSIZE'(t >> RSH);
    endfunction

    always_comb begin
        x_sh  = x_q >>> i_q;
        y_sh  = y_q >>> i_q;
        a_i   = atan_z(i_q);
        d_pos = VEC_MODE ? y_q[DSIZE-1] : ~z_q[ZSIZE-1];
        if (d_pos) begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - a_i;
        end else begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + a_i;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [15:0] GAIN_K = 16'sh4DBA;
    logic signed [DSIZE+15:0] x_gain, y_gain;

    always_comb begin
        x_gain = xo_q * GAIN_K;
        y_gain = yo_q * GAIN_K;
    end
`endif

    // Handshake: an operand transfers on an edge where in_valid && in_ready, a result on an
    // edge where out_valid && out_ready; both readies/valids are pure state decodes.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            ST_RUN: begin
                if (i_q == LAST_I) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = ST_GAIN;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_GAIN: state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        state_dbg = state_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            z_q  <= '0;
            i_q  <= '0;
            xo_q <= '0;
            yo_q <= '0;
            zo_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            z_q  <= z_d;
            i_q  <= i_d;
            xo_q <= xo_d;
            yo_q <= yo_d;
            zo_q <= zo_d;
        end
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        z_d  = z_q;
        i_d  = i_q;
        xo_d = xo_q;
        yo_d = yo_q;
        zo_d = zo_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d = Xin;
                    y_d = Yin;
                    z_d = Zin;
                    i_d = '0;
                end
            end
            ST_RUN: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                i_d = i_q + 5'd1;
                // Result registers only change on the final micro-rotation
                if (i_q == LAST_I) begin
                    xo_d = x_rot;
                    yo_d = y_rot;
                    zo_d = z_rot;
                end
            end
            ST_GAIN: begin
`ifdef CORDIC_GAIN_COMP_EN
                xo_d = DSIZE'(x_gain >>> 15);
                yo_d = DSIZE'(y_gain >>> 15);
`endif
            end
            default: begin
            end
        endcase
    end

    assign Xout = xo_q;
    assign Yout = yo_q;
    assign Zout = zo_q;

endmodule

// File: doc/cordic_iter_rotation.md
# cordic_iter_rotation

Folded (iterative) CORDIC rotator that time-multiplexes one X/Y/Z micro-rotation datapath over ITER cycles under a valid/ready handshake. It replaces the fixed one-stage-per-iteration pipeline where area matters more than throughput. It supports both ROTT (drive Z to 0) and VECTOR (drive Y to 0) modes. It sits between the sample front end and any consumer of magnitude/phase or rotated vectors.

## Interface
- DSIZE, 16: signed width of X/Y data.
- ZSIZE, 16: signed angle width; full scale 2^ZSIZE = 360°, so 0x2000 = 45° at ZSIZE=16. Legal range 8..32.
- ITER, 12: micro-rotations per operation. Legal range 1..24.
- ROTTMODE, "ROTT": "ROTT" or "VECTOR". Any other value is an elaboration error.
- clock  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept operand (high only in IDLE).
- Xin, Yin  in  DSIZE  signed operand vector.
- Zin  in  ZSIZE  signed operand angle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Xout, Yout  out  DSIZE  signed result vector (registered).
- Zout  out  ZSIZE  signed residual/accumulated angle (registered).

## Operation
- FSM states: IDLE, RUN, GAIN (only with macro), DONE.
- IDLE: in_ready=1. When in_valid&in_ready at an edge, the block captures X/Y/Z into working registers, clears counter i to 0, and moves to RUN.
- RUN: on each edge, one micro-rotation with index i, then i++. On the edge with i==ITER-1, the block moves to DONE (or to GAIN) and loads Xout/Yout/Zout.
- Direction d=+1/-1:
  - ROTT: d=+1 if Z>=0.
  - VECTOR: d=+1 if Y<0.
- Update per step:
  - X' = X − d·(Y>>>i)
  - Y' = Y + d·(X>>>i)
  - Z' = Z − d·A[i]
- Shifts are arithmetic. Shifts with i≥DSIZE yield 0 or −1 and are legal.
- A[i] = round(atan(2^-i)/2π·2^32), held as a 32-bit constant table and right-shifted by 32−ZSIZE with round-half-up. Check values: A[0]=0x20000000, A[1]=0x12E4051E.
- All adds are DSIZE/ZSIZE wide with two's-complement wrap and no saturation.
- Headroom: the caller keeps |X|,|Y| < 2^(DSIZE-1)/1.647.
- Gain is uncompensated (≈1.6468 for ITER≥8) unless the macro below is defined.
- No quadrant pre-rotation. ROTT converges only for |Zin| ≤ 99.8°; VECTOR converges only for Xin>0.
- DONE: out_valid=1. Xout/Yout/Zout hold stable until out_valid&out_ready, then the FSM moves to IDLE. The outputs keep their last value afterwards.
- Reset values: state IDLE, in_ready=1 after reset, out_valid=0, Xout/Yout/Zout=0, i=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No output is produced and no partial result is exposed.

## Timing
- Accept at edge k. out_valid is high in the cycle after edge k+ITER (k+ITER+1 with the macro).
- in_ready is a decode of state only. There is no combinational path from in_valid or out_ready to any output.
- In DONE, in_ready=0. An in_valid asserted in the same cycle as the out_ready handshake is accepted no earlier than the following IDLE cycle.
- Minimum spacing between accepted operands is ITER+2 cycles (ITER+3 with the macro).
- ITER=1: RUN lasts one edge and the FSM goes straight to DONE.

## Configuration
- CORDIC_GAIN_COMP_EN defined:
  - Adds the GAIN state: one cycle in which Xout and Yout are each multiplied by constant 0x4DBA (0.607253, Q1.15) and arithmetically shifted right by 15 (truncating).
  - Zout passes through unchanged.
  - Adds one cycle of latency.
- Not defined:
  - No GAIN state and no multipliers.
  - Outputs carry the raw CORDIC gain.

## Test plan
- ROTT, defaults, Xin=10000, Yin=0, Zin=0x2000 → Xout and Yout each 11645±4, |Zout|≤2. out_valid first high 12 cycles after the accept edge.
- VECTOR, Xin=10000, Yin=10000, Zin=0 → Xout=23290±6, |Yout|≤3, Zout=0x2000±2.
- Backpressure: out_ready held low 5 cycles in DONE → outputs and out_valid stable, in_ready=0. On out_ready=1, IDLE the next cycle with in_ready=1.
- Reset pulse on the 4th RUN cycle → next cycle shows state IDLE, out_valid=0, outputs 0. A following operand still yields the correct ROTT result.
- Back-to-back: in_valid held high with 3 operands, out_ready=1 → exactly 3 results in order, accepts spaced 14 cycles apart.
- With CORDIC_GAIN_COMP_EN, ROTT Xin=10000, Yin=0, Zin=0 → Xout=10000±3, |Yout|≤3. Latency is 13 cycles.
